// File: rtl/reg_pair_sequencer_if.sv
// reg_pair_sequencer_if: byte-level request/response channel between the CPU datapath and the nibble sequencer.
interface reg_pair_sequencer_if #(parameter int ADDR_W = 4);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-2:0] req_reg;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_rdata;
  modport master (
    output req_valid, req_write, req_reg, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_write, req_reg, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/reg_pair_sequencer.sv
// reg_pair_sequencer: splits 8-bit register reads/writes into lo/hi nibble accesses on a 4-bit register file.
module reg_pair_sequencer #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  reg_pair_sequencer_if.slave bus,
  output logic              busy,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [3:0]        rf_wdata,
  input  logic [3:0]        rf_rdata
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WR_LO  = 3'd1;
  localparam logic [2:0] WR_HI  = 3'd2;
  localparam logic [2:0] RD_LO  = 3'd3;
  localparam logic [2:0] RD_HI  = 3'd4;
  localparam logic [2:0] RD_CAP = 3'd5;
  localparam logic [2:0] RSP    = 3'd6;
  logic [2:0]        state, nxt;
  logic [ADDR_W-2:0] reg_q, cur_reg;
  logic [7:0]        wdata_q, cur_wd;
  logic [3:0]        lo_q;
  logic [7:0]        rsp_rdata_q;
  logic              rsp_valid_q;
  assign busy          = state != IDLE;
  assign bus.req_ready = rst & (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  // rf_* are registered from the next state, so the request fields must bypass the latch on acceptance
  assign cur_reg = (state == IDLE) ? bus.req_reg : reg_q;
  assign cur_wd  = (state == IDLE) ? bus.req_wdata : wdata_q;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = bus.req_valid ? (bus.req_write ? WR_LO : RD_LO) : IDLE;
      WR_LO:   nxt = WR_HI;
      WR_HI:   nxt = IDLE;
      RD_LO:   nxt = RD_HI;
      RD_HI:   nxt = RD_CAP;
      RD_CAP:  nxt = RSP;
      RSP:     nxt = bus.rsp_ready ? IDLE : RSP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      reg_q       <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rf_wr_en    <= 1'b0;
      rf_addr     <= '0;
      rf_wdata    <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.req_valid) begin
        reg_q   <= bus.req_reg;
        wdata_q <= bus.req_wdata;
      end
      rf_wr_en <= (nxt == WR_LO) || (nxt == WR_HI);
      rf_addr  <= (nxt == WR_LO || nxt == RD_LO) ? {cur_reg, 1'b0} :
                  (nxt == WR_HI || nxt == RD_HI) ? {cur_reg, 1'b1} : '0;
      rf_wdata <= (nxt == WR_LO) ? cur_wd[3:0] : (nxt == WR_HI) ? cur_wd[7:4] : 4'h0;
      // register file read data lags the presented address by one cycle
      if (state == RD_HI) lo_q <= rf_rdata;
      if (state == RD_CAP) rsp_rdata_q <= {rf_rdata, lo_q};
      rsp_valid_q <= nxt == RSP;
    end
  end
endmodule

// File: tb/tb_reg_pair_sequencer.sv
// tb_reg_pair_sequencer: randomized self-checking bench with a registered 16x4 register file and a byte-level reference model.
module tb_reg_pair_sequencer;
  localparam int AW = 4;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  reg_pair_sequencer_if #(.ADDR_W(AW)) bus();
  logic          busy, rf_wr_en;
  logic [AW-1:0] rf_addr;
  logic [3:0]    rf_wdata, rf_rdata;
  reg_pair_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .rf_wr_en(rf_wr_en),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );
  logic [3:0]  mem [16];
  logic        loaded = 0;
  logic [63:0] seed;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= seed[i*4 +: 4];
      loaded <= 1;
    end else if (rf_wr_en) mem[rf_addr] <= rf_wdata;
    rf_rdata <= mem[rf_addr];
  end
  logic [7:0] ref_regs [8];
  int total = 0;
  int bad = 0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [31:0] got, want;
    rst = 0;
    repeat (3) tick();
    got = {bus.rsp_valid, bus.rsp_rdata, rf_wr_en, rf_addr, rf_wdata, busy, bus.req_ready};
    want = 0;
    total++;
    if (got !== want) begin bad++; $display("FAIL reset_outputs: got %h want %h", got, want); end
    rst = 1;
    #1;
    got = {busy, bus.req_ready};
    want = 32'b01;
    total++;
    if (got !== want) begin bad++; $display("FAIL reset_release: got %h want %h", got, want); end
  endtask
  task automatic test_write(input logic [2:0] r, input logic [7:0] d);
    logic [31:0] got, want;
    bus.req_valid = 1; bus.req_write = 1; bus.req_reg = r; bus.req_wdata = d;
    tick();
    bus.req_valid = 0; bus.req_wdata = ~d; bus.req_reg = ~r;
    got = {busy, bus.req_ready, rf_wr_en, rf_addr, rf_wdata};
    want = {1'b1, 1'b0, 1'b1, r, 1'b0, d[3:0]};
    total++;
    if (got !== want) begin bad++; $display("FAIL wr_lo reg%0d: got %h want %h", r, got, want); end
    tick();
    got = {busy, bus.req_ready, rf_wr_en, rf_addr, rf_wdata};
    want = {1'b1, 1'b0, 1'b1, r, 1'b1, d[7:4]};
    total++;
    if (got !== want) begin bad++; $display("FAIL wr_hi reg%0d: got %h want %h", r, got, want); end
    tick();
    got = {busy, bus.req_ready, rf_wr_en, rf_wdata, bus.rsp_valid};
    want = {1'b0, 1'b1, 1'b0, 4'h0, 1'b0};
    total++;
    if (got !== want) begin bad++; $display("FAIL wr_done reg%0d: got %h want %h", r, got, want); end
    ref_regs[r] = d;
  endtask
  task automatic test_read(input logic [2:0] r, input int hold);
    logic [31:0] got, want;
    logic [7:0]  exp;
    exp = ref_regs[r];
    bus.req_valid = 1; bus.req_write = 0; bus.req_reg = r; bus.rsp_ready = (hold == 0);
    tick();
    bus.req_valid = 0; bus.req_reg = ~r;
    got = {rf_wr_en, rf_addr, rf_wdata, bus.rsp_valid, bus.req_ready};
    want = {1'b0, r, 1'b0, 4'h0, 1'b0, 1'b0};
    total++;
    if (got !== want) begin bad++; $display("FAIL rd_lo reg%0d: got %h want %h", r, got, want); end
    tick();
    got = {rf_wr_en, rf_addr, bus.rsp_valid};
    want = {1'b0, r, 1'b1, 1'b0};
    total++;
    if (got !== want) begin bad++; $display("FAIL rd_hi reg%0d: got %h want %h", r, got, want); end
    tick();
    got = {rf_wr_en, bus.rsp_valid, busy};
    want = {1'b0, 1'b0, 1'b1};
    total++;
    if (got !== want) begin bad++; $display("FAIL rd_cap reg%0d: got %h want %h", r, got, want); end
    tick();
    got = {bus.rsp_valid, bus.rsp_rdata, bus.req_ready, busy};
    want = {1'b1, exp, 1'b0, 1'b1};
    total++;
    if (got !== want) begin bad++; $display("FAIL rsp reg%0d: got %h want %h", r, got, want); end
    for (int i = 0; i < hold; i++) begin
      tick();
      got = {bus.rsp_valid, bus.rsp_rdata, bus.req_ready, rf_wr_en};
      want = {1'b1, exp, 1'b0, 1'b0};
      total++;
      if (got !== want) begin bad++; $display("FAIL rsp_hold reg%0d cyc%0d: got %h want %h", r, i, got, want); end
    end
    bus.rsp_ready = 1;
    tick();
    got = {bus.rsp_valid, bus.req_ready, busy};
    want = {1'b0, 1'b1, 1'b0};
    total++;
    if (got !== want) begin bad++; $display("FAIL rsp_done reg%0d: got %h want %h", r, got, want); end
  endtask
  task automatic test_top_index();
    test_write(3'd7, 8'h3C);
    test_read(3'd7, 5);
  endtask
  task automatic test_back_to_back();
    logic [31:0] got, want;
    int n;
    bus.req_valid = 1; bus.req_write = 1; bus.req_reg = 0; bus.req_wdata = 8'hFF; bus.rsp_ready = 1;
    tick();
    bus.req_write = 0;
    got = {bus.req_ready, rf_wr_en, rf_addr, rf_wdata};
    want = {1'b0, 1'b1, 4'd0, 4'hF};
    total++;
    if (got !== want) begin bad++; $display("FAIL b2b_wr_lo: got %h want %h", got, want); end
    tick();
    got = {bus.req_ready, rf_wr_en, rf_addr, rf_wdata};
    want = {1'b0, 1'b1, 4'd1, 4'hF};
    total++;
    if (got !== want) begin bad++; $display("FAIL b2b_wr_hi: got %h want %h", got, want); end
    ref_regs[0] = 8'hFF;
    tick();
    got = {31'd0, bus.req_ready};
    want = 1;
    total++;
    if (got !== want) begin bad++; $display("FAIL b2b_ready: got %h want %h", got, want); end
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      tick();
      n++;
      if (n == 1) bus.req_valid = 0;
    end
    got = {16'(n), 8'h00, bus.rsp_rdata};
    want = {16'd4, 8'h00, ref_regs[0]};
    total++;
    if (got !== want) begin bad++; $display("FAIL b2b_read latency/data: got %h want %h", got, want); end
    tick();
    got = {30'd0, bus.rsp_valid, bus.req_ready};
    want = 32'b01;
    total++;
    if (got !== want) begin bad++; $display("FAIL b2b_rsp_done: got %h want %h", got, want); end
  endtask
  task automatic test_reset_mid_write();
    logic [31:0] got, want;
    logic [3:0]  old3;
    old3 = mem[3];
    bus.req_valid = 1; bus.req_write = 1; bus.req_reg = 1; bus.req_wdata = 8'h12;
    tick();
    bus.req_valid = 0;
    tick();
    got = {rf_wr_en, rf_addr, rf_wdata};
    want = {1'b1, 4'd3, 4'h1};
    total++;
    if (got !== want) begin bad++; $display("FAIL rst_mid_in_wr_hi: got %h want %h", got, want); end
    #2 rst = 0;
    #1;
    got = {busy, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, rf_wr_en, rf_addr, rf_wdata};
    want = 0;
    total++;
    if (got !== want) begin bad++; $display("FAIL rst_async_clear: got %h want %h", got, want); end
    repeat (2) tick();
    got = {24'd0, mem[3], mem[2]};
    want = {24'd0, old3, 4'h2};
    total++;
    if (got !== want) begin bad++; $display("FAIL rst_partial_write: got %h want %h", got, want); end
    rst = 1;
    tick();
    got = {30'd0, bus.rsp_valid, bus.req_ready};
    want = 32'b01;
    total++;
    if (got !== want) begin bad++; $display("FAIL rst_no_rsp: got %h want %h", got, want); end
    ref_regs[1] = {old3, 4'h2};
    test_read(3'd1, 0);
  endtask
  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) test_write(3'($urandom_range(0, 7)), 8'($urandom));
      else test_read(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end
  endtask
  initial begin
    seed = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) ref_regs[i] = seed[i*8 +: 8];
    bus.req_valid = 0; bus.req_write = 0; bus.req_reg = 0; bus.req_wdata = 0; bus.rsp_ready = 0;
    test_reset();
    test_write(3'd3, 8'hA5);
    test_read(3'd3, 0);
    test_top_index();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_pair_sequencer.md
Name: reg_pair_sequencer

Overview:
- Initiator-side controller for the 4-bit-wide CPU register file.
- Presents 8-bit register reads and writes to the CPU datapath, and splits each into two nibble accesses on the register-file port: low nibble at even address, high nibble at odd address.
- Handles the register file's one-cycle registered read latency.
- Sits between instruction decode/ALU writeback and the register file.

Parameters:
- ADDR_W, 4, register-file nibble address width. Gives 2^(ADDR_W-1) byte registers.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low. Clears all state and outputs.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_reg  in  ADDR_W-1  byte register index.
- req_wdata  in  8  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  8  assembled read data.
- busy  out  1  high in any state other than IDLE.
- rf_wr_en  out  1  register-file write enable.
- rf_addr  out  ADDR_W  register-file nibble address.
- rf_wdata  out  4  register-file write nibble.
- rf_rdata  in  4  register-file read data. Registered: reflects the address presented in the previous cycle, and the old value on a same-cycle write.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rf_wr_en=0, rf_addr=0, rf_wdata=0, busy=0, internal captures=0.
  - req_ready=1 once rst=1.
- Reset mid-operation aborts the transaction; no response is produced. A low nibble already written stays written. This is an accepted partial write.
- All outputs except req_ready and busy are registered. rf_* values are valid during the cycle of the named state.
- FSM states: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_CAP, RSP.
- IDLE:
  - req_ready=1, rf_wr_en=0.
  - On req_valid: latch req_reg and req_wdata.
  - Go to WR_LO if req_write=1, else RD_LO.
- WR_LO: rf_wr_en=1, rf_addr={reg,0}, rf_wdata=wdata[3:0]. Next state WR_HI.
- WR_HI: rf_wr_en=1, rf_addr={reg,1}, rf_wdata=wdata[7:4]. Next state IDLE.
  - Writes produce no response.
  - Accept-to-ready latency is 3 cycles.
- RD_LO: rf_wr_en=0, rf_addr={reg,0}. Next state RD_HI.
- RD_HI: rf_addr={reg,1}; capture lo=rf_rdata. Next state RD_CAP.
- RD_CAP: capture hi=rf_rdata; rsp_rdata<= {hi, lo}. Next state RSP.
- RSP:
  - rsp_valid=1; rsp_rdata held stable.
  - On rsp_ready: rsp_valid<=0 and go to IDLE.
  - With rsp_ready held high, rsp_valid appears 4 cycles after acceptance and lasts exactly 1 cycle.
  - No new request is accepted until the cycle after the rsp handshake.
- rf_wr_en is never asserted outside WR_LO and WR_HI.
- rf_wdata is 0 when not writing.
- req_valid while busy is ignored (req_ready=0); the requester must hold it.
- Width rules:
  - rf_addr is the concatenation of req_reg and one nibble-select bit.
  - The top index (all ones) is a legal register and maps to addresses 2^ADDR_W-2 and 2^ADDR_W-1; no wrap beyond.
- Back-to-back: a write followed immediately by a read of the same register returns the new value, because transactions are serialized.

Test Plan:
- Reset release: rst low for 3 cycles -> all outputs 0 and busy=0. Asserting rst low mid-cycle clears outputs without waiting for a clk edge.
- Write reg 3 = 0xA5 -> cycle 1: rf_wr_en=1, rf_addr=6, rf_wdata=0x5. Cycle 2: rf_addr=7, rf_wdata=0xA. Cycle 3: req_ready=1, rf_wr_en=0.
- Read reg 3 after that write, rsp_ready=1 (bench model: 16x4 registered RAM) -> rf_addr 6 then 7. rsp_valid=1 with rsp_rdata=0xA5 exactly 4 cycles after accept, for 1 cycle.
- Read reg 7 = 0x3C with rsp_ready=0 for 5 cycles -> rsp_valid holds, rsp_rdata stays 0x3C, req_ready=0. Then rsp_ready=1 -> rsp_valid drops; req_ready=1 next cycle.
- Back-to-back write reg 0 = 0xFF then read reg 0, req_valid held throughout -> second request accepted only when req_ready returns. Read returns 0xFF, not the stale value.
- Assert rst low during WR_HI of a write of 0x12 to reg 1 -> immediate IDLE and all outputs 0. Address 2 holds 0x2 and address 3 is unchanged. No rsp_valid.
